// File: rtl/regfile_wb_sink_if.sv
// Bundle between writeback/decode and the architectural register file.
// Latency: none; carries combinational read data and the write triple.
// Backpressure: none; the register file accepts a write every cycle.
interface regfile_wb_sink_if #(
  parameter int N_REGS = 8,
  parameter int DATA_W = 16
);
  localparam int SEL_W = $clog2(N_REGS);

  logic [SEL_W-1:0]  read1RegSel;
  logic [SEL_W-1:0]  read2RegSel;
  logic [SEL_W-1:0]  writeRegSel;
  logic [DATA_W-1:0] writeData;
  logic              writeEn;
  logic [DATA_W-1:0] read1Data;
  logic [DATA_W-1:0] read2Data;
  logic              err;

  // Decode/writeback side: drives selects and the write triple.
  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    input  read1Data, read2Data, err
  );

  // Register file side.
  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    output read1Data, read2Data, err
  );
endinterface

// File: rtl/regfile_wb_sink.sv
// Architectural register file (N_REGS x DATA_W), 1 write port, 2 read ports.
// Latency: reads combinational; a write is visible the cycle after the edge.
// Backpressure: none; a write is accepted every cycle writeEn is high.
//
// Optional build macro REGFILE_WB_BYPASS_EN: when defined, a read whose
// select matches the in-flight write returns writeData in the same cycle,
// removing the writeback-to-decode hazard. Undefined (default): reads always
// return the stored array contents. N_REGS must be a power of two, and the
// interface instance must be built with the same N_REGS/DATA_W.
module regfile_wb_sink #(
  parameter int N_REGS = 8,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sink_if.slave   rf
);

  logic [DATA_W-1:0] regs [N_REGS];

  // Register array: synchronous clear has priority over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.writeEn) begin
      regs[rf.writeRegSel] <= rf.writeData;
    end
  end

  // Read port 1: forced to zero while in reset so no stale or bypassed
  // value leaks out before the clear has landed.
  always_comb begin
    rf.read1Data = '0;
    if (!rst) begin
      rf.read1Data = regs[rf.read1RegSel];
`ifdef REGFILE_WB_BYPASS_EN
      if (rf.writeEn && (rf.read1RegSel == rf.writeRegSel)) begin
        rf.read1Data = rf.writeData;
      end
`endif
    end
  end

  // Read port 2: same behaviour as port 1, bypassing independently.
  always_comb begin
    rf.read2Data = '0;
    if (!rst) begin
      rf.read2Data = regs[rf.read2RegSel];
`ifdef REGFILE_WB_BYPASS_EN
      if (rf.writeEn && (rf.read2RegSel == rf.writeRegSel)) begin
        rf.read2Data = rf.writeData;
      end
`endif
    end
  end

  // Control-input sanity flag: only meaningful in a 4-state simulator and
  // reduces to constant 0 in hardware. writeRegSel matters only while a
  // write is actually requested.
  always_comb begin
    rf.err = 1'b0;
    if ($isunknown(rf.writeEn) ||
        $isunknown(rf.read1RegSel) ||
        $isunknown(rf.read2RegSel)) begin
      rf.err = 1'b1;
    end else if (rf.writeEn && $isunknown(rf.writeRegSel)) begin
      rf.err = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink: stimulus pushes expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_regfile_wb_sink;

  localparam int NR = 8;
  localparam int DW = 16;

  localparam int F_RD1 = 0;
  localparam int F_RD2 = 1;
  localparam int F_ERR = 2;

  typedef struct {
    string       name;
    int          field;
    logic [15:0] exp;
  } chk_t;

  logic clk;
  logic rst;

  regfile_wb_sink_if #(.N_REGS(NR), .DATA_W(DW)) rf ();

  regfile_wb_sink #(.N_REGS(NR), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  chk_t        sbQ[$];
  int          nTests = 0;
  int          nFail  = 0;
  logic [15:0] mdl [NR];
  logic [15:0] got;
  logic [15:0] wrVals [NR];
  chk_t        cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      cur = sbQ.pop_front();
      case (cur.field)
        F_RD1:   got = rf.read1Data;
        F_RD2:   got = rf.read2Data;
        default: got = {15'b0, rf.err};
      endcase
      nTests = nTests + 1;
      if (got !== cur.exp) begin
        nFail = nFail + 1;
        $display("FAIL %s: got %h, expected %h", cur.name, got, cur.exp);
      end
    end
  end

  task automatic expect_val(input string nm, input int fld, input logic [15:0] v);
    chk_t c;
    c.name  = nm;
    c.field = fld;
    c.exp   = v;
    sbQ.push_back(c);
  endtask

  task automatic drive(input logic r, input logic we, input logic [2:0] ws,
                       input logic [15:0] wd, input logic [2:0] r1, input logic [2:0] r2);
    rst            = r;
    rf.writeEn     = we;
    rf.writeRegSel = ws;
    rf.writeData   = wd;
    rf.read1RegSel = r1;
    rf.read2RegSel = r2;
  endtask

  // Advance one edge; the reference model commits what the DUT should commit.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NR; i++) mdl[i] = 16'h0000;
    end else if (rf.writeEn) begin
      mdl[rf.writeRegSel] = rf.writeData;
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run is bounded in simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, nTests=%0d", nTests);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = 16'h0000;
    wrVals[0] = 16'hA5A5; wrVals[1] = 16'h0001; wrVals[2] = 16'h8000;
    wrVals[3] = 16'hBEEF; wrVals[4] = 16'h7FFF; wrVals[5] = 16'h1234;
    wrVals[6] = 16'h5A5A; wrVals[7] = 16'hFFFE;

    // Power-up reset
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    tick(); tick();

    // Fill every register with FFFF, then reset for two cycles
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, 1'b1, 3'(i), 16'hFFFF, 3'd0, 3'd0);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7);
    expect_val("prefill_r2", F_RD1, 16'hFFFF);
    expect_val("prefill_r7", F_RD2, 16'hFFFF);
    tick();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd6);
    tick();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd4);
    expect_val("in_reset_rd1", F_RD1, 16'h0000);
    expect_val("in_reset_rd2", F_RD2, 16'h0000);
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(NR - 1 - i));
      expect_val($sformatf("post_reset_rd1_r%0d", i), F_RD1, 16'h0000);
      expect_val($sformatf("post_reset_rd2_r%0d", NR - 1 - i), F_RD2, 16'h0000);
      expect_val("post_reset_err", F_ERR, 16'h0000);
      tick();
    end

    // Write disabled: R2 must keep 0
    drive(1'b0, 1'b0, 3'd2, 16'h7777, 3'd2, 3'd2);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0);
    expect_val("wr_disable_r2", F_RD1, 16'h0000);
    tick();

    // Consecutive writes R3, R5 then dual readback
    drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
    expect_val("readback_r3", F_RD1, 16'hBEEF);
    expect_val("readback_r5", F_RD2, 16'h1234);
    tick();

    // Full sweep including R0, which is writable
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, 1'b1, 3'(i), wrVals[i], 3'd0, 3'd0);
      tick();
    end
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'((i + 1) % NR));
      expect_val($sformatf("sweep_rd1_r%0d", i), F_RD1, wrVals[i]);
      expect_val($sformatf("sweep_rd2_r%0d", (i + 1) % NR), F_RD2, mdl[(i + 1) % NR]);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    expect_val("r0_rd1", F_RD1, 16'hA5A5);
    expect_val("r0_rd2_same_sel", F_RD2, 16'hA5A5);
    tick();

    // Collision on R4
    drive(1'b0, 1'b1, 3'd4, 16'h0011, 3'd0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd4, 16'h0022, 3'd4, 3'd0);
`ifdef REGFILE_WB_BYPASS_EN
    expect_val("collision_same_cycle", F_RD1, 16'h0022);
`else
    expect_val("collision_same_cycle", F_RD1, 16'h0011);
`endif
    expect_val("collision_other_port", F_RD2, 16'hA5A5);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4);
    expect_val("collision_next_rd1", F_RD1, 16'h0022);
    expect_val("collision_next_rd2", F_RD2, 16'h0022);
    tick();

    // Back-to-back writes to R7: last one wins
    drive(1'b0, 1'b1, 3'd7, 16'h1111, 3'd0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd7, 16'h2222, 3'd0, 3'd7);
`ifdef REGFILE_WB_BYPASS_EN
    expect_val("b2b_mid", F_RD2, 16'h2222);
`else
    expect_val("b2b_mid", F_RD2, 16'h1111);
`endif
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd6);
    expect_val("b2b_last_wins", F_RD1, 16'h2222);
    expect_val("b2b_neighbour", F_RD2, 16'h5A5A);
    tick();

    // Reset with a concurrent write to R6: write dropped, no bypass
    drive(1'b1, 1'b1, 3'd6, 16'hCAFE, 3'd6, 3'd6);
    expect_val("rst_write_no_bypass_rd1", F_RD1, 16'h0000);
    expect_val("rst_write_no_bypass_rd2", F_RD2, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd4);
    expect_val("rst_write_r6", F_RD1, 16'h0000);
    expect_val("rst_write_r4_cleared", F_RD2, 16'h0000);
    tick();

    // Error flag: unknown select. A 2-state simulator cannot hold X, so the
    // expectation follows what the stimulus signal actually carries.
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'bxxx);
    expect_val("err_rd2_x", F_ERR, {15'b0, $isunknown(rf.read2RegSel)});
    tick();
    drive(1'b0, 1'b0, 3'bxxx, 16'h0, 3'd1, 3'd1);
    expect_val("err_ws_x_we0", F_ERR, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1);
    expect_val("err_restored", F_ERR, 16'h0000);
    expect_val("err_no_state_rd1", F_RD1, 16'h0000);
    expect_val("err_no_state_rd2", F_RD2, 16'h0000);
    tick();

    // Drain the scoreboard
    @(negedge clk);
    #1;
    nTests = nTests + 1;
    if (sbQ.size() != 0) begin
      nFail = nFail + 1;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
